// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the multi-cycle ALU: operation
//                encodings, FSM state encoding and op classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_AND   = 4'b0010,
        OP_OR    = 4'b0011,
        OP_XOR   = 4'b0100,
        OP_SLT   = 4'b0101,
        OP_SLL   = 4'b0110,
        OP_SRL   = 4'b0111,
        OP_SRA   = 4'b1000,
        OP_SLTU  = 4'b1001,
        OP_MUL   = 4'b1010,
        OP_MULHU = 4'b1011,
        OP_DIV   = 4'b1100,
        OP_DIVU  = 4'b1101,
        OP_REM   = 4'b1110,
        OP_REMU  = 4'b1111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Multiply and divide ops (1010..1111) use the iterative datapath.
    function automatic logic is_iter_op(input op_e op);
        return op[3] && (op[2] || op[1]);
    endfunction

    // Divide/remainder ops (11xx).
    function automatic logic is_div_op(input op_e op);
        return op[3] && op[2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_mc_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc_if
//  Description : Request/response bundle of the multi-cycle ALU.
//                Request : in_valid/in_ready handshake with op, a, b.
//                Response: out_valid/out_ready handshake with result, zero.
//                master = requester/consumer side, slave = ALU side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface alu_mc_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : One-bit-per-cycle shift-add multiplier / restoring divider.
//                Runs exactly XLEN iterations after i_start.
//                Ports: clk, rst_n (sync, active-low), i_start, i_mul
//                (1=multiply, 0=divide), i_signed (signed divide), i_a, i_b,
//                o_done (high during the final iteration), o_lo
//                (product low / quotient), o_hi (product high / remainder).
//                o_lo/o_hi carry the final values while o_done is high.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter #(
    parameter int XLEN = 32
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    input  wire logic            i_start,
    input  wire logic            i_mul,
    input  wire logic            i_signed,
    input  wire logic [XLEN-1:0] i_a,
    input  wire logic [XLEN-1:0] i_b,
    output logic                 o_done,
    output logic [XLEN-1:0]      o_lo,
    output logic [XLEN-1:0]      o_hi
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW-1:0] c_last = SHW'(XLEN - 1);

    logic            r_busy;
    logic [SHW-1:0]  r_cnt;
    logic            r_mul;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_acc;     // product high / partial remainder
    logic [XLEN-1:0] r_q;       // multiplier shifting out / quotient shifting in
    logic [XLEN-1:0] r_m;       // multiplicand / divisor magnitude

    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_acc_nx;
    logic [XLEN-1:0] w_q_nx;

    always_comb begin
        w_a_mag = (i_signed && i_a[XLEN-1]) ? -i_a : i_a;
        w_b_mag = (i_signed && i_b[XLEN-1]) ? -i_b : i_b;
    end

    always_comb begin
        // Multiply: add multiplicand when the current multiplier LSB is set,
        // then shift the {acc, q} pair right, carry included.
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        // Divide: bring in next dividend bit; the remainder stays below the
        // divisor, so the XLEN-bit difference is exact when it is taken.
        w_shift = {r_acc, r_q[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, r_m});
        w_diff  = w_shift[XLEN-1:0] - r_m;
        if (r_mul) begin
            w_acc_nx = w_sum[XLEN:1];
            w_q_nx   = {w_sum[0], r_q[XLEN-1:1]};
        end else if (w_ge) begin
            w_acc_nx = w_diff;
            w_q_nx   = {r_q[XLEN-2:0], 1'b1};
        end else begin
            w_acc_nx = w_shift[XLEN-1:0];
            w_q_nx   = {r_q[XLEN-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mul   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_acc   <= '0;
            r_q     <= '0;
            r_m     <= '0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_mul   <= i_mul;
            r_neg_q <= !i_mul && i_signed && (i_a[XLEN-1] ^ i_b[XLEN-1]);
            r_neg_r <= !i_mul && i_signed && i_a[XLEN-1];
            r_acc   <= '0;
            r_q     <= i_mul ? i_b : w_a_mag;
            r_m     <= i_mul ? i_a : w_b_mag;
        end else if (r_busy) begin
            r_acc <= w_acc_nx;
            r_q   <= w_q_nx;
            r_cnt <= r_cnt + SHW'(1);
            if (r_cnt == c_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        o_done = r_busy && (r_cnt == c_last);
        o_lo   = r_neg_q ? -w_q_nx   : w_q_nx;
        o_hi   = r_neg_r ? -w_acc_nx : w_acc_nx;
    end

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle ALU with valid/ready handshakes. Logic, shift,
//                compare and add/sub finish in one cycle; multiply/divide run
//                XLEN cycles in alu_muldiv_iter. Divide-by-zero and signed
//                overflow are resolved in one cycle.
//                Ports: clk, rst_n (sync, active-low), bus (alu_mc_if.slave:
//                in_valid/in_ready/op/a/b, out_valid/out_ready/result/zero).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc #(
    parameter int XLEN = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    alu_mc_if.slave   bus
);
    import alu_pkg::*;

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] c_min_neg = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    state_e          w_state_nx;
    op_e             r_op;
    logic [XLEN-1:0] r_result;
    logic            r_zero;

    op_e             w_op;
    logic            w_in_ready;
    logic            w_accept;
    logic [SHW-1:0]  w_shamt;
    logic            w_b_zero;
    logic            w_sovf;
    logic            w_special;
    logic            w_fast;
    logic [XLEN-1:0] w_fast_res;
    logic            w_iter_start;
    logic            w_iter_done;
    logic [XLEN-1:0] w_iter_lo;
    logic [XLEN-1:0] w_iter_hi;
    logic [XLEN-1:0] w_iter_res;

    // ---------------- request decode ----------------
    always_comb begin
        w_op         = op_e'(bus.op);
        w_accept     = bus.in_valid && w_in_ready;
        w_shamt      = bus.b[SHW-1:0];
        w_b_zero     = (bus.b == '0);
        w_sovf       = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                       (bus.a == c_min_neg) && (bus.b == '1);
        w_special    = is_div_op(w_op) && (w_b_zero || w_sovf);
        w_fast       = !is_iter_op(w_op) || w_special;
        w_iter_start = w_accept && !w_fast;
    end

    // Single-cycle results, including the divide special cases.
    always_comb begin
        w_fast_res = '0;
        case (w_op)
            OP_ADD:  w_fast_res = bus.a + bus.b;
            OP_SUB:  w_fast_res = bus.a - bus.b;
            OP_AND:  w_fast_res = bus.a & bus.b;
            OP_OR:   w_fast_res = bus.a | bus.b;
            OP_XOR:  w_fast_res = bus.a ^ bus.b;
            OP_SLT:  w_fast_res = {{(XLEN-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
            OP_SLL:  w_fast_res = bus.a << w_shamt;
            OP_SRL:  w_fast_res = bus.a >> w_shamt;
            OP_SRA:  w_fast_res = $unsigned($signed(bus.a) >>> w_shamt);
            OP_SLTU: w_fast_res = {{(XLEN-1){1'b0}}, (bus.a < bus.b)};
            // by zero: quotient all ones; signed overflow: quotient = a
            OP_DIV, OP_DIVU: w_fast_res = w_b_zero ? '1 : bus.a;
            // by zero: remainder = a; signed overflow: remainder = 0
            OP_REM, OP_REMU: w_fast_res = w_b_zero ? bus.a : '0;
            default: w_fast_res = '0;
        endcase
    end

    // ---------------- iterative datapath ----------------
    alu_muldiv_iter #(
        .XLEN (XLEN)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_iter_start),
        .i_mul    (!w_op[2]),
        .i_signed ((w_op == OP_DIV) || (w_op == OP_REM)),
        .i_a      (bus.a),
        .i_b      (bus.b),
        .o_done   (w_iter_done),
        .o_lo     (w_iter_lo),
        .o_hi     (w_iter_hi)
    );

    always_comb begin
        case (r_op)
            OP_MULHU, OP_REM, OP_REMU: w_iter_res = w_iter_hi;
            default:                   w_iter_res = w_iter_lo;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nx = w_fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (w_iter_done) begin
                    w_state_nx = ST_DONE;
                end
            end
            ST_DONE: begin
                // Result leaves this cycle; a same-cycle accept restarts
                // exactly as from IDLE.
                if (w_accept) begin
                    w_state_nx = w_fast ? ST_DONE : ST_CALC;
                end else if (bus.out_ready) begin
                    w_state_nx = ST_IDLE;
                end
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        w_in_ready    = 1'b0;
        bus.out_valid = 1'b0;
        case (r_state)
            ST_IDLE: w_in_ready = 1'b1;
            ST_CALC: w_in_ready = 1'b0;
            ST_DONE: begin
                w_in_ready    = bus.out_ready;
                bus.out_valid = 1'b1;
            end
            default: w_in_ready = 1'b0;
        endcase
        bus.in_ready = w_in_ready;
        bus.result   = r_result;
        bus.zero     = r_zero;
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op     <= OP_ADD;
            r_result <= '0;
            r_zero   <= 1'b1;
        end else if (w_accept) begin
            r_op <= w_op;
            if (w_fast) begin
                r_result <= w_fast_res;
                r_zero   <= (w_fast_res == '0);
            end
        end else if ((r_state == ST_CALC) && w_iter_done) begin
            r_result <= w_iter_res;
            r_zero   <= (w_iter_res == '0);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Directed self-checking bench for alu_mc (XLEN=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;
    import alu_pkg::*;

    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_mc_if #(.XLEN(XLEN)) bus ();

    alu_mc #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, wait for its result with a bounded wait, check
    // latency/result/zero, then consume it.
    task automatic run(input string tag, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int exp_lat);
        int lat;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        bus.a        = ~a;
        bus.b        = ~b;
        lat = 1;
        if (exp_lat > 1) check({tag, ".busy"}, 64'(bus.in_ready), 64'd0);
        while (!bus.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        check({tag, ".result"}, 64'(bus.result), 64'(exp));
        check({tag, ".zero"}, 64'(bus.zero), 64'(exp == 32'd0));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({tag, ".drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] held;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.op        = 4'd0;
        bus.a         = '0;
        bus.b         = '0;

        // reset state
        tick();
        tick();
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.result", 64'(bus.result), 64'd0);
        check("rst.zero", 64'(bus.zero), 64'd1);
        rst_n = 1'b1;
        tick();
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);

        // single-cycle ops
        run("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        run("sub",      OP_SUB,  32'd3,         32'd5,         32'hFFFF_FFFE, 1);
        run("and",      OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
        run("or",       OP_OR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1);
        run("xor",      OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        run("slt",      OP_SLT,  32'hFFFF_FFFF, 32'h1,         32'h1,         1);
        run("sltu",     OP_SLTU, 32'hFFFF_FFFF, 32'h1,         32'h0,         1);
        run("sll",      OP_SLL,  32'h1,         32'h21,        32'h2,         1);
        run("srl",      OP_SRL,  32'h8000_0000, 32'h4,         32'h0800_0000, 1);
        run("sra",      OP_SRA,  32'h8000_0000, 32'h21,        32'hC000_0000, 1);

        // iterative multiply / divide
        run("mul",      OP_MUL,   32'h1_0000,    32'h1_0000,    32'h0,         33);
        run("mulhu",    OP_MULHU, 32'h1_0000,    32'h1_0000,    32'h1,         33);
        run("mul_max",  OP_MUL,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         33);
        run("mulhu_max",OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run("div_neg",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        run("rem_neg",  OP_REM,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        run("div_negb", OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        run("rem_negb", OP_REM,   32'd7,         32'hFFFF_FFFE, 32'h1,         33);
        run("divu",     OP_DIVU,  32'd100,       32'd7,         32'd14,        33);
        run("remu",     OP_REMU,  32'd100,       32'd7,         32'd2,         33);

        // special cases, one cycle
        run("divu_z",   OP_DIVU,  32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        run("remu_z",   OP_REMU,  32'd5,         32'd0,         32'd5,         1);
        run("div_ovf",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run("rem_ovf",  OP_REM,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1);

        // backpressure: result held while out_ready stays low
        bus.op       = OP_XOR;
        bus.a        = 32'h1234_5678;
        bus.b        = 32'h0F0F_0F0F;
        bus.in_valid = 1'b1;
        tick();
        bus.op = OP_ADD;
        bus.a  = 32'd1;
        bus.b  = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("stall.out_valid", 64'(bus.out_valid), 64'd1);
            check("stall.result", 64'(bus.result), 64'h1D3B_5977);
            check("stall.in_ready", 64'(bus.in_ready), 64'd0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("stall.drained", 64'(bus.out_valid), 64'd0);

        // back-to-back single-cycle throughput
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.op       = OP_ADD;
            bus.a        = 32'(i * 3 + 1);
            bus.b        = 32'd100;
            bus.in_valid = 1'b1;
            tick();
            check("b2b.out_valid", 64'(bus.out_valid), 64'd1);
            check("b2b.result", 64'(bus.result), 64'(i * 3 + 101));
        end
        bus.in_valid = 1'b0;
        tick();
        bus.out_ready = 1'b0;
        check("b2b.drained", 64'(bus.out_valid), 64'd0);

        // reset in the middle of a DIVU aborts it
        bus.op       = OP_DIVU;
        bus.a        = 32'd100;
        bus.b        = 32'd7;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort.out_valid", 64'(bus.out_valid), 64'd0);
        check("abort.result", 64'(bus.result), 64'd0);
        check("abort.zero", 64'(bus.zero), 64'd1);
        check("abort.in_ready", 64'(bus.in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.out_valid) seen++;
        end
        check("abort.no_result", 64'(seen), 64'd0);
        run("after_abort", OP_ADD, 32'd2, 32'd3, 32'd5, 1);

        held = 32'h0;
        run("zero_and", OP_AND, 32'hAAAA_AAAA, 32'h5555_5555, held, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter XLEN, default 32, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 Parameter SHW, default $clog2(XLEN), shift-amount width; derived, not overridden.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 op  input  4  operation code (see REQ-012).
REQ-008 a, b  input  XLEN each  operands; sampled only on accept.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes result this cycle.
REQ-011 result  output  XLEN; zero  output  1  high when result is all zeros; both valid only with out_valid.

Function
REQ-012 op encoding: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT (signed), 0110 SLL, 0111 SRL, 1000 SRA, 1001 SLTU, 1010 MUL (low XLEN), 1011 MULHU (high XLEN, unsigned), 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU.
REQ-013 Accept occurs on a cycle with in_valid && in_ready; operands and op are latched then and may change afterward.
REQ-014 Shifts use b[SHW-1:0] only; higher bits of b are ignored.
REQ-015 ADD/SUB/MUL wrap modulo 2^XLEN; SLT/SLTU return 1 or 0, zero-extended.
REQ-016 FSM states: IDLE, CALC, DONE.
REQ-017 IDLE: in_ready=1; on accept of single-cycle op (0000-1001) or a div special case (REQ-020/021), go to DONE with result loaded; on accept of any other mul/div op, go to CALC.
REQ-018 CALC: in_ready=0; iterative shift-add multiply or restoring divide, one bit per cycle, exactly XLEN cycles, then DONE.
REQ-019 Latency: single-cycle op accepted in cycle N gives out_valid in N+1; iterative op accepted in N gives out_valid in N+XLEN+1.
REQ-020 Divide by zero (b==0): DIV/DIVU quotient = all ones; REM/REMU = a; latency 1.
REQ-021 Signed overflow (DIV/REM, a=most negative, b=-1): DIV = a, REM = 0; latency 1.
REQ-022 Signed DIV/REM: operate on magnitudes; quotient negated when signs differ; remainder takes sign of a.
REQ-023 DONE: out_valid=1; result/zero stable until out_ready; on out_ready, go IDLE.
REQ-024 In DONE, in_ready = out_ready; a same-cycle accept is taken as if from IDLE, giving back-to-back single-cycle throughput of 1 per cycle.
REQ-025 in_valid arriving while in CALC is not accepted and is not lost by the requester (in_ready=0).

Reset
REQ-026 With rst_n low at a clock edge: state=IDLE, out_valid=0, result=0, zero=1, iteration counter=0, in_ready=1 from next cycle.
REQ-027 Reset during CALC or DONE aborts the operation; no result is produced for it.

Structure
REQ-028 Shared package alu_pkg holds op encoding constants/enum and FSM state enum.
REQ-029 Iterative datapath is one sub-module alu_muldiv_iter (start, signed-mode, a, b, done, quotient/product, remainder/high); alu_mc holds FSM, single-cycle ops, special-case detection and output register.

Verification (XLEN=32)
REQ-030 ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid at N+1, result=0, zero=1.
REQ-031 SLT a=0xFFFFFFFF, b=1 -> result=1; SLTU same operands -> result=0; SRA a=0x80000000, b=0x21 -> result=0xC0000000 (shift 1).
REQ-032 MUL a=0x10000, b=0x10000 -> result=0 at N+33; MULHU same -> result=1.
REQ-033 DIV a=-7, b=2 -> result=0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU a=5, b=0 -> 0xFFFFFFFF at N+1; DIV a=0x80000000, b=-1 -> 0x80000000.
REQ-034 out_ready held low 5 cycles after result -> result/out_valid stable, in_ready=0; back-to-back ADDs with out_ready=1 -> one result per cycle.
REQ-035 rst_n low at cycle 10 of a DIVU -> out_valid stays 0, result=0, state IDLE, next request served normally.
